// File: rtl/tank_pkg.sv
// Shared tank types, grid constants and the muzzle-position helper.
`default_nettype none

package tank_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef struct packed {
    logic [5:0] x;
    logic [5:0] y;
  } cell_t;

  localparam int GRID_PX     = 10;
  localparam int TANK_HALF   = 2;
  localparam int FIELD_W_DEF = 64;
  localparam int FIELD_H_DEF = 48;

  // The bullet spawns one cell beyond the tank's leading edge.
  function automatic cell_t muzzle(input logic [5:0] x, input logic [5:0] y, input dir_t dir);
    cell_t c;
    c.x = x;
    c.y = y;
    case (dir)
      UP:      c.y = y - 6'(TANK_HALF + 1);
      DOWN:    c.y = y + 6'(TANK_HALF + 1);
      LEFT:    c.x = x - 6'(TANK_HALF + 1);
      default: c.x = x + 6'(TANK_HALF + 1);
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tank_edge_prober.sv
// Walks the five cells in front of the tank's leading edge and OR-reduces the wall-map replies.
`default_nettype none

module tank_edge_prober
  import tank_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  dir_t       i_dir,
  input  logic [5:0] i_x,
  input  logic [5:0] i_y,
  output logic       o_probe_valid,
  output logic [5:0] o_probe_x,
  output logic [5:0] o_probe_y,
  input  logic       i_probe_blocked,
  output logic       o_done,
  output logic       o_blocked
);

  typedef enum logic [1:0] {
    P_IDLE  = 2'd0,
    P_PROBE = 2'd1,
    P_WAIT  = 2'd2
  } pstate_t;

  pstate_t    state_q, state_d;
  logic [2:0] k_q, k_d;
  logic       blocked_q, blocked_d;
  logic       pend_q;
  logic [5:0] k6;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= P_IDLE;
      k_q       <= 3'd0;
      blocked_q <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      blocked_q <= blocked_d;
      pend_q    <= o_probe_valid;
    end
  end

  // A reply belongs to the probe issued on the previous cycle, hence the pend_q gate.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    blocked_d     = blocked_q | (pend_q & i_probe_blocked);
    o_probe_valid = 1'b0;
    o_done        = 1'b0;
    o_blocked     = blocked_q | (pend_q & i_probe_blocked);
    case (state_q)
      P_IDLE: begin
        if (i_start) begin
          state_d   = P_PROBE;
          k_d       = 3'd0;
          blocked_d = 1'b0;
        end
      end
      P_PROBE: begin
        o_probe_valid = 1'b1;
        if (k_q == 3'd4) state_d = P_WAIT;
        else             k_d     = k_q + 3'd1;
      end
      P_WAIT: begin
        o_done  = 1'b1;
        state_d = P_IDLE;
      end
      default: state_d = P_IDLE;
    endcase
  end

  always_comb begin
    k6        = {3'b000, k_q};
    o_probe_x = i_x;
    o_probe_y = i_y;
    case (i_dir)
      UP: begin
        o_probe_x = i_x - 6'(TANK_HALF) + k6;
        o_probe_y = i_y - 6'(TANK_HALF + 1);
      end
      DOWN: begin
        o_probe_x = i_x - 6'(TANK_HALF) + k6;
        o_probe_y = i_y + 6'(TANK_HALF + 1);
      end
      LEFT: begin
        o_probe_x = i_x - 6'(TANK_HALF + 1);
        o_probe_y = i_y - 6'(TANK_HALF) + k6;
      end
      default: begin
        o_probe_x = i_x + 6'(TANK_HALF + 1);
        o_probe_y = i_y - 6'(TANK_HALF) + k6;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/tank_motion_ctrl.sv
// One tank's position/facing control: frame-tick turning, probed one-cell moves and rate-limited fire.
`default_nettype none

module tank_motion_ctrl
  import tank_pkg::*;
#(
  parameter int FIELD_W     = FIELD_W_DEF,
  parameter int FIELD_H     = FIELD_H_DEF,
  parameter int INIT_X      = 8,
  parameter int INIT_Y      = 40,
  parameter int INIT_DIR    = 0,
  parameter int MOVE_PERIOD = 2,
  parameter int FIRE_CD     = 30
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_tick,
  input  logic       i_alive,
  input  logic [3:0] i_cmd_dir,
  input  logic       i_cmd_fire,
  output logic       o_probe_valid,
  output logic [5:0] o_probe_x,
  output logic [5:0] o_probe_y,
  input  logic       i_probe_blocked,
  output logic [5:0] o_tank_x,
  output logic [5:0] o_tank_y,
  output logic [1:0] o_tank_dir,
  output logic       o_fire,
  output logic [5:0] o_fire_x,
  output logic [5:0] o_fire_y,
  output logic [1:0] o_fire_dir,
  output logic       o_busy
);

  localparam int STEP_W = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam int CD_W   = $clog2(FIRE_CD + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MOVE   = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        x_q, x_d, y_q, y_d;
  dir_t              dir_q, dir_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CD_W-1:0]   cd_q, cd_d;
  logic              blocked_q, blocked_d;
  logic              fire_q, fire_d;
  logic [5:0]        fire_x_q, fire_x_d, fire_y_q, fire_y_d;
  dir_t              fire_dir_q, fire_dir_d;

  dir_t  key_dir;
  logic  key_any, cmd_tick, legal, start, pr_done, pr_blocked;
  cell_t mz;

  tank_edge_prober u_prober (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_start         (start),
    .i_dir           (dir_q),
    .i_x             (x_q),
    .i_y             (y_q),
    .o_probe_valid   (o_probe_valid),
    .o_probe_x       (o_probe_x),
    .o_probe_y       (o_probe_y),
    .i_probe_blocked (i_probe_blocked),
    .o_done          (pr_done),
    .o_blocked       (pr_blocked)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      x_q        <= 6'(INIT_X);
      y_q        <= 6'(INIT_Y);
      dir_q      <= dir_t'(2'(INIT_DIR));
      step_q     <= '0;
      cd_q       <= '0;
      blocked_q  <= 1'b0;
      fire_q     <= 1'b0;
      fire_x_q   <= 6'd0;
      fire_y_q   <= 6'd0;
      fire_dir_q <= UP;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      cd_q       <= cd_d;
      blocked_q  <= blocked_d;
      fire_q     <= fire_d;
      fire_x_q   <= fire_x_d;
      fire_y_q   <= fire_y_d;
      fire_dir_q <= fire_dir_d;
    end
  end

  always_comb begin
    key_any = |i_cmd_dir;
    if      (i_cmd_dir[0]) key_dir = UP;
    else if (i_cmd_dir[1]) key_dir = DOWN;
    else if (i_cmd_dir[2]) key_dir = LEFT;
    else                   key_dir = RIGHT;
    // Compare against the current centre so the decremented value never has to wrap.
    case (dir_q)
      UP:      legal = y_q > 6'(TANK_HALF);
      DOWN:    legal = y_q < 6'(FIELD_H - TANK_HALF - 1);
      LEFT:    legal = x_q > 6'(TANK_HALF);
      default: legal = x_q < 6'(FIELD_W - TANK_HALF - 1);
    endcase
    mz = muzzle(x_q, y_q, dir_q);
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    dir_d      = dir_q;
    step_d     = step_q;
    cd_d       = cd_q;
    blocked_d  = blocked_q;
    fire_d     = 1'b0;
    fire_x_d   = fire_x_q;
    fire_y_d   = fire_y_q;
    fire_dir_d = fire_dir_q;
    start      = 1'b0;
    cmd_tick   = i_frame_tick & i_alive;

    case (state_q)
      S_IDLE: begin
        if (cmd_tick && key_any) begin
          if (key_dir != dir_q) begin
            dir_d  = key_dir;
            step_d = '0;
          end else if (step_q == STEP_W'(MOVE_PERIOD - 1)) begin
            step_d = '0;
            if (legal) begin
              start   = 1'b1;
              state_d = S_MOVE;
            end
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end else if (cmd_tick) begin
          step_d = '0;
        end
      end
      S_MOVE: begin
        if (pr_done) begin
          blocked_d = pr_blocked;
          state_d   = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (!blocked_q) begin
          case (dir_q)
            UP:      y_d = y_q - 6'd1;
            DOWN:    y_d = y_q + 6'd1;
            LEFT:    x_d = x_q - 6'd1;
            default: x_d = x_q + 6'd1;
          endcase
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The reload tick itself is the last tick of the cooldown, giving exactly FIRE_CD ticks between shots.
    if (i_frame_tick) begin
      if (cmd_tick && i_cmd_fire && (cd_q <= CD_W'(1))) begin
        fire_d     = 1'b1;
        fire_x_d   = mz.x;
        fire_y_d   = mz.y;
        fire_dir_d = dir_q;
        cd_d       = CD_W'(FIRE_CD);
      end else if (cd_q != '0) begin
        cd_d = cd_q - CD_W'(1);
      end
    end
  end

  assign o_tank_x   = x_q;
  assign o_tank_y   = y_q;
  assign o_tank_dir = dir_q;
  assign o_fire     = fire_q;
  assign o_fire_x   = fire_x_q;
  assign o_fire_y   = fire_y_q;
  assign o_fire_dir = fire_dir_q;
  assign o_busy     = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_tank_motion_ctrl.sv
// Directed bench for tank_motion_ctrl with a one-cell wall-map responder.
`default_nettype none

module tb_tank_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       alive = 1'b1;
  logic [3:0] cmd_dir = 4'd0;
  logic       cmd_fire = 1'b0;
  logic       probe_blocked = 1'b0;
  logic       pv, fire, busy;
  logic [5:0] px, py, tx, ty, fx, fy;
  logic [1:0] tdir, fdir;

  logic       blk_en = 1'b0;
  logic [5:0] blk_x = 6'd0, blk_y = 6'd0;
  int         probe_cnt = 0;
  int         errors = 0;
  int         checks = 0;

  tank_motion_ctrl dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_frame_tick    (tick),
    .i_alive         (alive),
    .i_cmd_dir       (cmd_dir),
    .i_cmd_fire      (cmd_fire),
    .o_probe_valid   (pv),
    .o_probe_x       (px),
    .o_probe_y       (py),
    .i_probe_blocked (probe_blocked),
    .o_tank_x        (tx),
    .o_tank_y        (ty),
    .o_tank_dir      (tdir),
    .o_fire          (fire),
    .o_fire_x        (fx),
    .o_fire_y        (fy),
    .o_fire_dir      (fdir),
    .o_busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    probe_blocked <= pv && blk_en && (px == blk_x) && (py == blk_y);
    if (pv) probe_cnt <= probe_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns 1 ns after the edge that sampled the tick.
  task automatic do_tick();
    @(posedge clk);
    #1 tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    tick     = 1'b0;
    alive    = 1'b1;
    cmd_dir  = 4'd0;
    cmd_fire = 1'b0;
    blk_en   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    wait_cycles(1);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({tx, ty, tdir} !== {6'd8, 6'd40, 2'd0}) begin
      errors++; $display("FAIL reset_pos: got x=%0d y=%0d dir=%0d expected 8 40 0", tx, ty, tdir);
    end
    checks++;
    if ({busy, pv, fire} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got busy=%b pv=%b fire=%b expected 0 0 0", busy, pv, fire);
    end
  endtask

  task automatic test_move_up();
    apply_reset();
    cmd_dir = 4'b0001;
    do_tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL up_tick1_busy: got %b expected 0", busy); end
    wait_cycles(2);
    do_tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL up_busy: got %b expected 1", busy); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({pv, px, py} !== {1'b1, 6'(6 + k), 6'd37}) begin
        errors++; $display("FAIL up_probe%0d: got v=%b (%0d,%0d) expected 1 (%0d,37)", k, pv, px, py, 6 + k);
      end
      wait_cycles(1);
    end
    checks++;
    if ({pv, busy} !== 2'b01) begin errors++; $display("FAIL up_wait: got pv=%b busy=%b expected 0 1", pv, busy); end
    wait_cycles(1);
    checks++;
    if (ty !== 6'd40) begin errors++; $display("FAIL up_y_early: got %0d expected 40", ty); end
    wait_cycles(1);
    checks++;
    if ({ty, busy} !== {6'd39, 1'b0}) begin
      errors++; $display("FAIL up_y_step1: got y=%0d busy=%b expected 39 0", ty, busy);
    end
    do_tick();
    wait_cycles(2);
    do_tick();
    wait_cycles(7);
    checks++;
    if ({tx, ty} !== {6'd8, 6'd38}) begin errors++; $display("FAIL up_y_step2: got (%0d,%0d) expected (8,38)", tx, ty); end
  endtask

  task automatic test_turn_blocked();
    apply_reset();
    cmd_dir = 4'b1000;
    blk_x = 6'd11; blk_y = 6'd42; blk_en = 1'b1;
    do_tick();
    checks++;
    if ({tdir, tx, busy} !== {2'd3, 6'd8, 1'b0}) begin
      errors++; $display("FAIL turn_right: got dir=%0d x=%0d busy=%b expected 3 8 0", tdir, tx, busy);
    end
    wait_cycles(2);
    do_tick();
    wait_cycles(2);
    do_tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({pv, px, py} !== {1'b1, 6'd11, 6'(38 + k)}) begin
        errors++; $display("FAIL right_probe%0d: got v=%b (%0d,%0d) expected 1 (11,%0d)", k, pv, px, py, 38 + k);
      end
      wait_cycles(1);
    end
    wait_cycles(2);
    checks++;
    if ({tx, ty, busy} !== {6'd8, 6'd40, 1'b0}) begin
      errors++; $display("FAIL right_blocked: got x=%0d y=%0d busy=%b expected 8 40 0", tx, ty, busy);
    end
    blk_en = 1'b0;
    do_tick();
    wait_cycles(2);
    do_tick();
    wait_cycles(7);
    checks++;
    if (tx !== 6'd9) begin errors++; $display("FAIL right_free: got x=%0d expected 9", tx); end
  endtask

  task automatic test_boundary();
    int snap;
    apply_reset();
    cmd_dir = 4'b0001;
    repeat (38) begin
      do_tick();
      wait_cycles(2);
      do_tick();
      wait_cycles(8);
    end
    checks++;
    if ({tx, ty} !== {6'd8, 6'd2}) begin errors++; $display("FAIL edge_reach: got (%0d,%0d) expected (8,2)", tx, ty); end
    snap = probe_cnt;
    repeat (2) begin
      do_tick();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL edge_busy: got %b expected 0", busy); end
      wait_cycles(8);
    end
    checks++;
    if (probe_cnt !== snap) begin errors++; $display("FAIL edge_probes: got %0d probes expected 0", probe_cnt - snap); end
    checks++;
    if (ty !== 6'd2) begin errors++; $display("FAIL edge_hold: got y=%0d expected 2", ty); end
  endtask

  task automatic test_fire();
    apply_reset();
    cmd_fire = 1'b1;
    for (int t = 0; t <= 60; t++) begin
      do_tick();
      checks++;
      if (fire !== ((t % 30) == 0)) begin
        errors++; $display("FAIL fire_t%0d: got %b expected %b", t, fire, (t % 30) == 0);
      end
      if (t == 0) begin
        checks++;
        if ({fx, fy, fdir} !== {6'd8, 6'd37, 2'd0}) begin
          errors++; $display("FAIL fire_muzzle: got (%0d,%0d) dir=%0d expected (8,37) 0", fx, fy, fdir);
        end
        wait_cycles(1);
        checks++;
        if (fire !== 1'b0) begin errors++; $display("FAIL fire_pulse: got %b expected 0", fire); end
      end
    end
    cmd_fire = 1'b0;
  endtask

  task automatic test_priority();
    apply_reset();
    cmd_dir = 4'b0100;
    do_tick();
    checks++;
    if (tdir !== 2'd2) begin errors++; $display("FAIL prio_left: got dir=%0d expected 2", tdir); end
    cmd_dir = 4'b0101;
    wait_cycles(2);
    do_tick();
    checks++;
    if ({tdir, busy} !== {2'd0, 1'b0}) begin
      errors++; $display("FAIL prio_up: got dir=%0d busy=%b expected 0 0", tdir, busy);
    end
    wait_cycles(8);
    checks++;
    if ({tx, ty} !== {6'd8, 6'd40}) begin errors++; $display("FAIL prio_nomove: got (%0d,%0d) expected (8,40)", tx, ty); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    cmd_dir = 4'b0001;
    do_tick();
    wait_cycles(2);
    do_tick();
    do_tick();
    wait_cycles(5);
    checks++;
    if ({ty, busy} !== {6'd39, 1'b0}) begin
      errors++; $display("FAIL busy_tick_move: got y=%0d busy=%b expected 39 0", ty, busy);
    end
    do_tick();
    wait_cycles(8);
    checks++;
    if (ty !== 6'd39) begin errors++; $display("FAIL busy_tick_drop: got y=%0d expected 39", ty); end
  endtask

  task automatic test_reset_mid_probe();
    apply_reset();
    cmd_dir = 4'b0100;
    do_tick();
    wait_cycles(2);
    do_tick();
    wait_cycles(2);
    do_tick();
    wait_cycles(1);
    checks++;
    if ({pv, tdir} !== {1'b1, 2'd2}) begin
      errors++; $display("FAIL mid_probe_pre: got pv=%b dir=%0d expected 1 2", pv, tdir);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx, ty, tdir, busy, pv} !== {6'd8, 6'd40, 2'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL mid_probe_reset: got x=%0d y=%0d dir=%0d busy=%b pv=%b expected 8 40 0 0 0",
                         tx, ty, tdir, busy, pv);
    end
    cmd_dir = 4'd0;
    @(negedge clk) rst_n = 1'b1;
    wait_cycles(1);
  endtask

  task automatic test_dead();
    apply_reset();
    alive    = 1'b0;
    cmd_dir  = 4'b0010;
    cmd_fire = 1'b1;
    do_tick();
    checks++;
    if ({tdir, fire, busy} !== {2'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL dead_ignore: got dir=%0d fire=%b busy=%b expected 0 0 0", tdir, fire, busy);
    end
    alive    = 1'b1;
    cmd_fire = 1'b0;
    cmd_dir  = 4'd0;
  endtask

  initial begin
    test_reset();
    test_move_up();
    test_turn_blocked();
    test_boundary();
    test_fire();
    test_priority();
    test_back_to_back();
    test_reset_mid_probe();
    test_dead();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
